inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Parametrised successor to the free-running PC fetch stage. Issues sequential instruction requests to instruction memory over a req/gnt + rvalid interface, with a bounded number of outstanding requests.
- Buffers returned instructions, tagged with their PC, in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump/trap): flushes the FIFO and discards stale in-flight responses.
- Sits between the core's control/execute redirect source and the decode stage.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, fetch buffer entries and maximum outstanding requests. Power of two, ≥2.

Ports:
- clk  in  1  core clock.
- rstn  in  1  synchronous active-low reset.
- boot_addr  in  XLEN  first fetch address, sampled while rstn=0.
- redirect_valid  in  1  redirect request.
- redirect_pc  in  XLEN  new fetch address. Bits [1:0] are ignored and treated as 0.
- imem_req  out  1  memory request valid.
- imem_addr  out  XLEN  request address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  XLEN  response instruction.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts.
- id_inst  out  XLEN  head instruction.
- id_pc  out  XLEN  head instruction address.

Behaviour:
- Reset (clk edge with rstn=0):
  - state=BOOT, pc_q=boot_addr with bits [1:0] forced to 0.
  - FIFO empty, outstanding=0, drop_cnt=0.
  - imem_req=0, id_valid=0; id_inst, id_pc = 0.
  - Reset asserted mid-operation abandons all in-flight requests. Responses arriving after reset release with outstanding=0 are ignored.
- States:
  - BOOT: lasts one cycle, then RUN.
  - RUN: normal fetch.
  - FLUSH: discarding stale responses.
- Issue rule: imem_req = (state==RUN) & !redirect_valid & (outstanding + fifo_count < DEPTH); imem_addr=pc_q.
  - Accept = imem_req & imem_gnt. On accept: pc_q += 4 (modulo 2^XLEN, 0xFFFFFFFC wraps to 0), the address is pushed into the in-flight address queue, outstanding += 1.
  - Requests may be held across cycles without gnt; imem_addr stays stable while held.
- Response: imem_rvalid returns in-order data, one response per accepted request, at the earliest the cycle after accept. imem_rvalid with outstanding=0 is a protocol error and is ignored.
  - RUN: the response is pushed as {inst, pc from address queue} into the FIFO and outstanding -= 1. The credit rule guarantees the FIFO is never overrun.
  - FLUSH: the response is discarded, outstanding -= 1, drop_cnt -= 1.
- Decode side:
  - id_valid = (fifo_count != 0), with id_inst/id_pc from the FIFO head.
  - Pop on id_valid & id_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - A response can appear at id_valid no earlier than the cycle after imem_rvalid (registered FIFO, no bypass).
  - Fetch-to-decode latency with an immediate gnt and a 1-cycle memory is 2 cycles from request.
- Redirect (redirect_valid=1, any state except BOOT; ignored in BOOT):
  - No accept occurs that cycle, because imem_req is forced low.
  - A decode pop occurring that same cycle completes normally.
  - Next edge: FIFO cleared, pc_q=redirect_pc, drop_cnt = outstanding after this cycle's response. That value equals the stale in-flight count; any response arriving in the redirect cycle itself is discarded.
  - Next state = FLUSH if drop_cnt≠0, else RUN.
- FLUSH:
  - imem_req=0.
  - When the last stale response is discarded (drop_cnt 1→0), the next state is RUN and fetch resumes at pc_q the following cycle.
  - A redirect during FLUSH overwrites pc_q and keeps counting the remaining drops.
- Simultaneous redirect and response in RUN: the response is discarded, not pushed.
- Counters are $clog2(DEPTH)+1 bits wide; outstanding and drop_cnt never exceed DEPTH.

Test Plan:
- Reset with boot_addr=0x0000_1000, gnt=1, 1-cycle memory, id_ready=1:
  - Required: imem_req=0 in the first cycle after reset release.
  - Required: imem_addr sequence 0x1000, 0x1004, 0x1008…
  - Required: id_pc follows the same sequence with matching id_inst, no gaps after warm-up.
- Backpressure with id_ready=0 and DEPTH=4: exactly 4 accepts (0x1000–0x100C), then imem_req=0. Raising id_ready for 1 cycle pops 0x1000, and exactly one new request, 0x1010, follows.
- Redirect to 0x2002 with 3 requests outstanding:
  - Required: FIFO empties, the 3 responses are dropped, imem_req stays low until the 3rd response.
  - Required: next imem_addr=0x2000; the first id_pc after the redirect is 0x2000.
- Redirect arriving in FLUSH, and redirect coinciding with imem_rvalid: only the last redirect target is fetched, and no stale instruction ever appears at id_valid.
- Wrap-around with boot_addr=0xFFFF_FFF8: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rstn low for one cycle mid-stream with 2 outstanding: id_valid=0 and imem_req=0 for one cycle, then fetch restarts at boot_addr. Late responses are ignored.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Sequential instruction fetch stage: credit-limited imem requests, PC-tagged
// fetch FIFO towards decode, and redirect handling that drops stale responses.
module inst_fetch_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] boot_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]       DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0]   ADDR_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   outstanding_d;
  logic [CW-1:0]   drop_cnt_q;
  logic [CW-1:0]   fifo_count_q;

  logic [XLEN-1:0] fifo_inst [DEPTH];
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [AW-1:0]   fifo_wr_q;
  logic [AW-1:0]   fifo_rd_q;

  logic [XLEN-1:0] aq_addr [DEPTH];
  logic [AW-1:0]   aq_wr_q;
  logic [AW-1:0]   aq_rd_q;

  logic            redirect;
  logic            accept;
  logic            rsp;
  logic            push;
  logic            pop;
  logic [CW:0]     credit_used;

  always_comb begin
    redirect      = redirect_valid & (state_q != BOOT);
    credit_used   = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    accept        = imem_req & imem_gnt;
    rsp           = imem_rvalid & (outstanding_q != '0);
    push          = rsp & (state_q == RUN) & ~redirect;
    pop           = id_valid & id_ready;
    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, FLUSH: begin
        if (redirect) begin
          state_d = (outstanding_d != '0) ? FLUSH : RUN;
        end else if ((state_q == FLUSH) &&
                     ((drop_cnt_q == '0) || (rsp && (drop_cnt_q == CW'(1))))) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == RUN) & ~redirect_valid & (credit_used < DEPTH_C);
    imem_addr = pc_q;
    id_valid  = (fifo_count_q != '0);
    id_inst   = id_valid ? fifo_inst[fifo_rd_q] : '0;
    id_pc     = id_valid ? fifo_pc[fifo_rd_q]   : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q          <= boot_addr & ADDR_MASK;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_count_q  <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      aq_wr_q       <= '0;
      aq_rd_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (accept) begin
        pc_q    <= pc_q + XLEN'(4);
        aq_wr_q <= aq_wr_q + 1'b1;
      end
      if (rsp) begin
        aq_rd_q <= aq_rd_q + 1'b1;
      end
      if (redirect) begin
        // Redirect cycle never accepts, so every request still in flight
        // after this cycle's response is stale.
        pc_q         <= redirect_pc & ADDR_MASK;
        drop_cnt_q   <= outstanding_d;
        fifo_count_q <= '0;
        fifo_wr_q    <= '0;
        fifo_rd_q    <= '0;
      end else begin
        if ((state_q == FLUSH) && rsp) begin
          drop_cnt_q <= drop_cnt_q - 1'b1;
        end
        if (push) begin
          fifo_wr_q <= fifo_wr_q + 1'b1;
        end
        if (pop) begin
          fifo_rd_q <= fifo_rd_q + 1'b1;
        end
        fifo_count_q <= fifo_count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      aq_addr[aq_wr_q] <= pc_q;
    end
    if (push) begin
      fifo_inst[fifo_wr_q] <= imem_rdata;
      fifo_pc[fifo_wr_q]   <= aq_addr[aq_rd_q];
    end
  end

endmodule
